bu_pipe: RTL and testbench
==========================

Name: bu_pipe

Overview:
Parametrised, pipelined branch resolution unit for the execute stage. Resolves conditional branches (signed and unsigned), JAL and JALR, and computes the link value. Checks the outcome against the front-end prediction and produces a registered redirect/flush request. Uses valid/ready handshakes on both sides and keeps saturating branch/mispredict statistics counters.

Parameters:
XLEN, 32, datapath width; operand, pc, immediate and target width.
CNT_W, 32, width of each statistics counter.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
valid_i  in  1  operation presented
ready_o  out  1  unit can accept this cycle
cmd_i  in  8  one-hot op: [0]BEQ [1]BNE [2]BLT [3]BGE [4]BLTU [5]BGEU [6]JAL [7]JALR
rs1_data_i  in  XLEN  operand 1
rs2_data_i  in  XLEN  operand 2
immediat_i  in  XLEN  sign-extended offset
pc_data_i  in  XLEN  pc of the branch
pred_taken_i  in  1  front-end predicted taken
pred_target_i  in  XLEN  front-end predicted target
flush_i  in  1  kill in-flight and incoming op
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
taken_o  out  1  resolved taken
redirect_o  out  1  mispredict: front end must refetch
pc_nxt_o  out  XLEN  correct next pc (target if taken, else pc+4)
data_o  out  XLEN  link value pc+4 for JAL/JALR, else 0
exc_misalign_o  out  1  target misaligned (optional feature)
stat_clr_i  in  1  synchronous clear of counters
stat_br_o  out  CNT_W  resolved ops count
stat_mp_o  out  CNT_W  mispredict count

Behaviour:
- Reset is asynchronous and active-high. In reset: valid_o=0 and all result registers=0. Counters=0.
- One output register stage, latency 1. Input accepted when valid_i & ready_o. ready_o = ~valid_o | ready_i, so full throughput is possible.
- Output held stable while valid_o & ~ready_i.
- Compare uses an (XLEN+1)-bit subtraction:
  - BLT/BGE: operands sign-extended.
  - BLTU/BGEU: operands zero-extended.
  - Sign bit of the result gives less-than.
- BEQ/BNE use XOR-reduce equality.
- Target:
  - JALR: (rs1+imm) with bit0 cleared.
  - All others: pc+imm.
  - Additions wrap modulo 2^XLEN.
- taken: condition result for conditional ops; 1 for JAL/JALR.
- pc_nxt_o = taken ? target : pc+4. pc+4 wraps.
- redirect_o = (taken != pred_taken_i) | (taken & target != pred_target_i). Valid only while valid_o=1; otherwise 0.
- cmd_i all zero or non-one-hot with valid_i: op is accepted, taken=0, redirect = pred_taken_i, data_o=0.
- flush_i:
  - Clears valid_o next cycle, whether or not ready_i is asserted.
  - Blocks capture of a same-cycle input, and ready_o is forced to 0.
  - Flush dominates a simultaneous accept.
- Counters:
  - stat_br_o increments once per result handed off (valid_o & ready_i).
  - stat_mp_o increments on the same handoff when redirect_o=1.
  - Both saturate at 2^CNT_W-1.
  - stat_clr_i has priority over an increment in the same cycle.
  - Flushed ops are not counted.
- Reset mid-operation: the pending result is discarded and no handoff occurs.

Optional Feature:
Macro BU_MISALIGN_CHECK_EN.
- Defined:
  - exc_misalign_o = valid_o & taken & (target[1:0] != 0).
  - When the exception fires, redirect_o is forced to 0 and the mispredict counter is not incremented.
- Undefined:
  - exc_misalign_o is tied to 0.
  - Targets are used unchecked.

Test Plan:
1. BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> next cycle valid_o=1, taken_o=1, pc_nxt=0x120, redirect=0.
2. BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1. BLTU with the same operands -> taken=0. With pred_taken=1 on BLTU -> redirect=1, pc_nxt=pc+4.
3. JALR, rs1=0x1001, imm=0x4, pc=0x200 -> pc_nxt=0x1004, data_o=0x204, taken=1. With BU_MISALIGN_CHECK_EN defined and rs1=0x1002 -> exc_misalign_o=1, redirect=0.
4. Back-to-back ops with ready_i=1 -> one result per cycle, ready_o stays 1. Hold ready_i=0 for 3 cycles -> outputs stable, ready_o=0.
5. flush_i with valid_o=1, ready_i=0, and a new valid_i in the same cycle -> next cycle valid_o=0, no new capture, counters unchanged.
6. Counters: with CNT_W=2, 5 handoffs -> stat_br_o saturates at 3. stat_clr_i together with a handoff -> counter reads 0 next cycle.

Source files
------------

// File: rtl/bu_pipe_if.sv
// Handshake and operand/result bundle for the branch resolution unit.
// master = producer/consumer side (front end and bench), slave = bu_pipe.
interface bu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [7:0]       cmd_i;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic [XLEN-1:0]  immediat_i;
    logic [XLEN-1:0]  pc_data_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  pred_target_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic             taken_o;
    logic             redirect_o;
    logic [XLEN-1:0]  pc_nxt_o;
    logic [XLEN-1:0]  data_o;
    logic             exc_misalign_o;
    logic             stat_clr_i;
    logic [CNT_W-1:0] stat_br_o;
    logic [CNT_W-1:0] stat_mp_o;

    modport master (
        output valid_i, cmd_i, rs1_data_i, rs2_data_i, immediat_i, pc_data_i,
               pred_taken_i, pred_target_i, flush_i, ready_i, stat_clr_i,
        input  ready_o, valid_o, taken_o, redirect_o, pc_nxt_o, data_o,
               exc_misalign_o, stat_br_o, stat_mp_o
    );

    modport slave (
        input  valid_i, cmd_i, rs1_data_i, rs2_data_i, immediat_i, pc_data_i,
               pred_taken_i, pred_target_i, flush_i, ready_i, stat_clr_i,
        output ready_o, valid_o, taken_o, redirect_o, pc_nxt_o, data_o,
               exc_misalign_o, stat_br_o, stat_mp_o
    );
endinterface

// File: rtl/bu_pipe.sv
// Pipelined branch resolution unit: resolves branches/JAL/JALR, flags mispredicts.
// Optional target misalignment exception enabled by defining BU_MISALIGN_CHECK_EN.
module bu_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    bu_pipe_if.slave   bus
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    function automatic logic less_than(input logic signed [XLEN:0] a,
                                       input logic signed [XLEN:0] b);
        logic signed [XLEN:0] d;
        d = a - b;
        return d[XLEN];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic                   signed_cmp_p0;
    logic signed [XLEN:0]   op_a_p0, op_b_p0;
    logic                   lt_p0, eq_p0, taken_p0, redir_p0, mis_p0, is_jalr_p0;
    logic [XLEN-1:0]        target_p0, link_p0, pc_nxt_p0, data_p0;
    logic                   accept_p0, handoff;

    // Stage p0: combinational resolve of the presented op
    always_comb begin
        signed_cmp_p0 = bus.cmd_i[2] | bus.cmd_i[3];
        op_a_p0 = signed_cmp_p0 ? {bus.rs1_data_i[XLEN-1], bus.rs1_data_i}
                                : {1'b0, bus.rs1_data_i};
        op_b_p0 = signed_cmp_p0 ? {bus.rs2_data_i[XLEN-1], bus.rs2_data_i}
                                : {1'b0, bus.rs2_data_i};
        lt_p0 = less_than(op_a_p0, op_b_p0);
        eq_p0 = ~|(bus.rs1_data_i ^ bus.rs2_data_i);

        taken_p0 = 1'b0;
        case (bus.cmd_i)
            8'h01:        taken_p0 = eq_p0;
            8'h02:        taken_p0 = ~eq_p0;
            8'h04, 8'h10: taken_p0 = lt_p0;
            8'h08, 8'h20: taken_p0 = ~lt_p0;
            8'h40, 8'h80: taken_p0 = 1'b1;
            default:      taken_p0 = 1'b0;
        endcase

        is_jalr_p0 = (bus.cmd_i == 8'h80);
        target_p0  = is_jalr_p0 ? ((bus.rs1_data_i + bus.immediat_i) & LSB_MASK)
                                : (bus.pc_data_i + bus.immediat_i);
        link_p0    = bus.pc_data_i + PC_STEP;
        pc_nxt_p0  = taken_p0 ? target_p0 : link_p0;
        data_p0    = (bus.cmd_i == 8'h40 || is_jalr_p0) ? link_p0 : '0;
        redir_p0   = (taken_p0 != bus.pred_taken_i) |
                     (taken_p0 & (target_p0 != bus.pred_target_i));
`ifdef BU_MISALIGN_CHECK_EN
        mis_p0     = taken_p0 & (target_p0[1:0] != 2'b00);
        // A misaligned target traps instead of refetching
        if (mis_p0) redir_p0 = 1'b0;
`else
        mis_p0     = 1'b0;
`endif
    end

    logic             vld_p1, taken_p1, redir_p1, mis_p1;
    logic [XLEN-1:0]  pc_nxt_p1, data_p1;
    logic [CNT_W-1:0] stat_br_p1, stat_mp_p1;

    assign bus.ready_o = ~bus.flush_i & (~vld_p1 | bus.ready_i);
    assign accept_p0   = bus.valid_i & bus.ready_o;
    assign handoff     = vld_p1 & bus.ready_i & ~bus.flush_i;

    // Stage p1: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            taken_p1  <= 1'b0;
            redir_p1  <= 1'b0;
            mis_p1    <= 1'b0;
            pc_nxt_p1 <= '0;
            data_p1   <= '0;
        end else if (bus.flush_i) begin
            vld_p1    <= 1'b0;
        end else if (accept_p0) begin
            vld_p1    <= 1'b1;
            taken_p1  <= taken_p0;
            redir_p1  <= redir_p0;
            mis_p1    <= mis_p0;
            pc_nxt_p1 <= pc_nxt_p0;
            data_p1   <= data_p0;
        end else if (bus.ready_i) begin
            vld_p1    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_p1 <= '0;
            stat_mp_p1 <= '0;
        end else if (bus.stat_clr_i) begin
            stat_br_p1 <= '0;
            stat_mp_p1 <= '0;
        end else if (handoff) begin
            stat_br_p1 <= sat_inc(stat_br_p1);
            if (redir_p1) stat_mp_p1 <= sat_inc(stat_mp_p1);
        end
    end

    assign bus.valid_o    = vld_p1;
    assign bus.taken_o    = taken_p1;
    assign bus.redirect_o = vld_p1 & redir_p1;
    assign bus.pc_nxt_o   = pc_nxt_p1;
    assign bus.data_o     = data_p1;
    assign bus.stat_br_o  = stat_br_p1;
    assign bus.stat_mp_o  = stat_mp_p1;
`ifdef BU_MISALIGN_CHECK_EN
    assign bus.exc_misalign_o = vld_p1 & mis_p1;
`else
    assign bus.exc_misalign_o = 1'b0;
    logic unused_mis;
    assign unused_mis = mis_p1;
`endif

endmodule

// File: tb/tb_bu_pipe.sv
// Directed self-checking bench for bu_pipe (XLEN=32, CNT_W=2 to reach saturation quickly).
module tb_bu_pipe;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
`ifdef BU_MISALIGN_CHECK_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif
    localparam logic [7:0] BEQ = 8'h01, BNE = 8'h02, BLT = 8'h04, BGE = 8'h08,
                           BLTU = 8'h10, BGEU = 8'h20, JAL = 8'h40, JALR = 8'h80;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] rs1, rs2, imm, pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        tk, rd, ex;
        logic [31:0] nxt, dat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    bu_pipe_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    bu_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [67:0] res;
    assign res = {bus.valid_o, bus.taken_o, bus.redirect_o, bus.exc_misalign_o,
                  bus.pc_nxt_o, bus.data_o};

    task automatic drive(input logic [7:0] cmd, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptgt);
        bus.valid_i = 1'b1; bus.cmd_i = cmd; bus.rs1_data_i = rs1; bus.rs2_data_i = rs2;
        bus.immediat_i = imm; bus.pc_data_i = pc; bus.pred_taken_i = pt; bus.pred_target_i = ptgt;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (res !== 68'h0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", res);
        end
        total++;
        if ({bus.ready_o, bus.stat_br_o, bus.stat_mp_o} !== {1'b1, 2'd0, 2'd0}) begin
            bad++; $display("FAIL reset_ready_cnt got=%b want=10000",
                            {bus.ready_o, bus.stat_br_o, bus.stat_mp_o});
        end
    endtask

    task automatic test_resolve();
        vec_t tbl [13];
        tbl = '{
            '{BEQ,  32'h5, 32'h5, 32'h20, 32'h100, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0, 32'h120, 32'h0},
            '{BLT,  32'hFFFFFFFF, 32'h1, 32'h40, 32'h300, 1'b1, 32'h340, 1'b1, 1'b0, 1'b0, 32'h340, 32'h0},
            '{BLTU, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h300, 1'b1, 32'h340, 1'b0, 1'b1, 1'b0, 32'h304, 32'h0},
            '{BGE,  32'hFFFFFFFF, 32'h1, 32'h40, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h304, 32'h0},
            '{BGEU, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h300, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h340, 32'h0},
            '{BNE,  32'h5, 32'h5, 32'h10, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0},
            '{BNE,  32'h5, 32'h6, 32'hFFFFFFF0, 32'h100, 1'b1, 32'hF0, 1'b1, 1'b0, 1'b0, 32'hF0, 32'h0},
            '{JAL,  32'h0, 32'h0, 32'hFFFFFFF8, 32'h400, 1'b1, 32'h3F0, 1'b1, 1'b1, 1'b0, 32'h3F8, 32'h404},
            '{JALR, 32'h1001, 32'h0, 32'h4, 32'h200, 1'b1, 32'h1004, 1'b1, 1'b0, 1'b0, 32'h1004, 32'h204},
            '{JALR, 32'h1002, 32'h0, 32'h4, 32'h200, 1'b1, 32'h1004, 1'b1, ~MIS, MIS, 32'h1006, 32'h204},
            '{BEQ,  32'h7, 32'h7, 32'h22, 32'h100, 1'b1, 32'h122, 1'b1, 1'b0, MIS, 32'h122, 32'h0},
            '{8'h03, 32'h1, 32'h1, 32'h8, 32'h500, 1'b1, 32'h508, 1'b0, 1'b1, 1'b0, 32'h504, 32'h0},
            '{8'h00, 32'h1, 32'h1, 32'h8, 32'h500, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h504, 32'h0}
        };
        bus.ready_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].cmd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].pc, tbl[i].pt, tbl[i].ptgt);
            step();
            total++;
            if (res !== {1'b1, tbl[i].tk, tbl[i].rd, tbl[i].ex, tbl[i].nxt, tbl[i].dat}) begin
                bad++;
                $display("FAIL resolve_%0d got=%h want=%h", i, res,
                         {1'b1, tbl[i].tk, tbl[i].rd, tbl[i].ex, tbl[i].nxt, tbl[i].dat});
            end
        end
        bus.valid_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc = 32'h1000 + 32'(16 * k);
            drive(JAL, 32'h0, 32'h0, 32'h10, pc, 1'b1, pc + 32'h10);
            step();
            total++;
            if ({bus.ready_o, res} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pc + 32'h10, pc + 32'h4}) begin
                bad++; $display("FAIL b2b_%0d got=%h want_pc_nxt=%h", k, {bus.ready_o, res}, pc + 32'h10);
            end
        end
        bus.ready_i = 1'b0;
        drive(JAL, 32'h0, 32'h0, 32'h10, 32'h2000, 1'b1, 32'h2010);
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({bus.ready_o, res} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1030, 32'h1024}) begin
                bad++; $display("FAIL hold_%0d got=%h want_pc_nxt=00001030 ready=0", c, {bus.ready_o, res});
            end
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        step();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++; $display("FAIL hold_release got=%b want=0", bus.valid_o);
        end
    endtask

    task automatic test_flush();
        bus.stat_clr_i = 1'b1;
        step();
        bus.stat_clr_i = 1'b0;
        bus.ready_i = 1'b0;
        drive(BLTU, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h300, 1'b1, 32'h340);
        step();
        total++;
        if ({bus.valid_o, bus.redirect_o} !== 2'b11) begin
            bad++; $display("FAIL flush_setup got=%b want=11", {bus.valid_o, bus.redirect_o});
        end
        drive(BEQ, 32'h5, 32'h5, 32'h20, 32'h100, 1'b0, 32'h0);
        bus.flush_i = 1'b1;
        #1;
        total++;
        if (bus.ready_o !== 1'b0) begin
            bad++; $display("FAIL flush_ready got=%b want=0", bus.ready_o);
        end
        step();
        total++;
        if ({bus.valid_o, bus.redirect_o, bus.stat_br_o, bus.stat_mp_o} !== 6'b0) begin
            bad++; $display("FAIL flush_kill got=%b want=000000",
                            {bus.valid_o, bus.redirect_o, bus.stat_br_o, bus.stat_mp_o});
        end
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        step();
        total++;
        if ({bus.valid_o, bus.stat_br_o} !== 3'b0) begin
            bad++; $display("FAIL flush_no_capture got=%b want=000", {bus.valid_o, bus.stat_br_o});
        end
    endtask

    task automatic test_counters();
        logic [1:0] exp;
        bus.ready_i = 1'b1;
        bus.stat_clr_i = 1'b1;
        step();
        bus.stat_clr_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(BLTU, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h300, 1'b1, 32'h340);
            step();
            exp = (i - 1 > 3) ? 2'd3 : 2'(i - 1);
            total++;
            if ({bus.stat_br_o, bus.stat_mp_o} !== {exp, exp}) begin
                bad++; $display("FAIL cnt_%0d got=%b want=%b", i, {bus.stat_br_o, bus.stat_mp_o}, {exp, exp});
            end
        end
        bus.valid_i = 1'b0;
        step();
        total++;
        if ({bus.stat_br_o, bus.stat_mp_o} !== 4'b1111) begin
            bad++; $display("FAIL cnt_sat got=%b want=1111", {bus.stat_br_o, bus.stat_mp_o});
        end
        drive(BLTU, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h300, 1'b1, 32'h340);
        step();
        bus.valid_i = 1'b0;
        bus.stat_clr_i = 1'b1;
        step();
        bus.stat_clr_i = 1'b0;
        total++;
        if ({bus.valid_o, bus.stat_br_o, bus.stat_mp_o} !== 5'b0) begin
            bad++; $display("FAIL cnt_clr_prio got=%b want=00000", {bus.valid_o, bus.stat_br_o, bus.stat_mp_o});
        end
        drive(BEQ, 32'h5, 32'h5, 32'h20, 32'h100, 1'b1, 32'h120);
        step();
        bus.valid_i = 1'b0;
        step();
        total++;
        if ({bus.stat_br_o, bus.stat_mp_o} !== 4'b0100) begin
            bad++; $display("FAIL cnt_no_mp got=%b want=0100", {bus.stat_br_o, bus.stat_mp_o});
        end
    endtask

    task automatic test_reset_mid();
        bus.ready_i = 1'b0;
        drive(JAL, 32'h0, 32'h0, 32'h10, 32'h600, 1'b0, 32'h0);
        step();
        bus.valid_i = 1'b0;
        total++;
        if (res !== {4'b1110, 32'h610, 32'h604}) begin
            bad++; $display("FAIL rst_mid_setup got=%h want=%h", res, {4'b1110, 32'h610, 32'h604});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({res, bus.stat_br_o} !== 70'h0) begin
            bad++; $display("FAIL rst_mid_async got=%h want=0", {res, bus.stat_br_o});
        end
        rst = 1'b0;
        bus.ready_i = 1'b1;
        step();
        total++;
        if ({bus.valid_o, bus.stat_br_o, bus.stat_mp_o} !== 5'b0) begin
            bad++; $display("FAIL rst_mid_no_handoff got=%b want=00000",
                            {bus.valid_o, bus.stat_br_o, bus.stat_mp_o});
        end
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.cmd_i = 8'h0; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
        bus.immediat_i = '0; bus.pc_data_i = '0; bus.pred_taken_i = 1'b0; bus.pred_target_i = '0;
        bus.flush_i = 1'b0; bus.ready_i = 1'b0; bus.stat_clr_i = 1'b0;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_resolve();
        test_back_to_back();
        test_flush();
        test_counters();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
